// File: rtl/rv_bus_ctrl_if.sv
// Bundle of fetch, data and Wishbone signals for rv_bus_ctrl.
// master = the bus controller, slave = the pipeline/bus side facing it.
interface rv_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // fetch redirect and instruction stream
  logic              i_flush;
  logic [ADDR_W-1:0] i_flush_addr;
  logic              o_instr_valid;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_instr_addr;
  logic              o_instr_err;
  logic              i_instr_ready;

  // load/store port
  logic              i_dreq;
  logic              i_dwe;
  logic [ADDR_W-1:0] i_daddr;
  logic [DATA_W-1:0] i_dwdata;
  logic [SEL_W-1:0]  i_dsel;
  logic              o_dack;
  logic [DATA_W-1:0] o_drdata;
  logic              o_derr;

  // Wishbone classic master
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_adr;
  logic [DATA_W-1:0] o_wb_dat;
  logic [SEL_W-1:0]  o_wb_sel;
  logic [DATA_W-1:0] i_wb_dat;
  logic              i_wb_ack;
  logic              i_wb_err;

  modport master (
    input  i_flush, i_flush_addr, i_instr_ready,
    input  i_dreq, i_dwe, i_daddr, i_dwdata, i_dsel,
    input  i_wb_dat, i_wb_ack, i_wb_err,
    output o_instr_valid, o_instr, o_instr_addr, o_instr_err,
    output o_dack, o_drdata, o_derr,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel
  );

  modport slave (
    output i_flush, i_flush_addr, i_instr_ready,
    output i_dreq, i_dwe, i_daddr, i_dwdata, i_dsel,
    output i_wb_dat, i_wb_ack, i_wb_err,
    input  o_instr_valid, o_instr, o_instr_addr, o_instr_err,
    input  o_dack, o_drdata, o_derr,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel
  );
endinterface

// File: rtl/rv_bus_ctrl.sv
// Wishbone master for the RV32 core: instruction prefetch FIFO plus
// load/store port. Data accesses win over prefetch, one transfer in flight.
module rv_bus_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                PF_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                TIMEOUT    = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rv_bus_ctrl_if.master bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  logic [1:0]        state;
  logic              wb_cyc, wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat;
  logic [SEL_W-1:0]  wb_sel;
  logic              dack, derr;
  logic [DATA_W-1:0] drdata;

  logic [ADDR_W-1:0] pc;
  logic              fetch_halt;
  logic              discard;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [DATA_W-1:0] fifo_instr [PF_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [PF_DEPTH];
  logic              fifo_err   [PF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic busy, tmo_hit, bus_err, bus_ok, done;
  logic fetch_done, data_done, issue_data, issue_fetch;
  logic push, pop, instr_valid;

  assign busy        = (state != IDLE);
  assign tmo_hit     = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  // error (or timeout) beats a simultaneous ack
  assign bus_err     = busy & (bus.i_wb_err | tmo_hit);
  assign bus_ok      = busy & bus.i_wb_ack & ~bus_err;
  assign done        = bus_err | bus_ok;
  assign fetch_done  = (state == FETCH) & done;
  assign data_done   = (state == DATA) & done;
  // dack still high means the old request is still held: do not reissue it
  assign issue_data  = (state == IDLE) & bus.i_dreq & ~dack;
  // no fetch in a flush cycle so the redirected pc is used
  assign issue_fetch = (state == IDLE) & ~bus.i_dreq & ~fetch_halt & ~bus.i_flush &
                       (count < CNT_W'(PF_DEPTH));
  assign instr_valid = (count != '0);
  assign push        = fetch_done & ~discard & ~bus.i_flush;
  assign pop         = instr_valid & bus.i_instr_ready & ~bus.i_flush;

  assign bus.o_wb_cyc      = wb_cyc;
  assign bus.o_wb_stb      = wb_cyc;
  assign bus.o_wb_we       = wb_we;
  assign bus.o_wb_adr      = wb_adr;
  assign bus.o_wb_dat      = wb_dat;
  assign bus.o_wb_sel      = wb_sel;
  assign bus.o_dack        = dack;
  assign bus.o_derr        = derr;
  assign bus.o_drdata      = drdata;
  assign bus.o_instr_valid = instr_valid;
  assign bus.o_instr       = fifo_instr[rd_ptr];
  assign bus.o_instr_addr  = fifo_addr[rd_ptr];
  assign bus.o_instr_err   = fifo_err[rd_ptr];

  // sequencer: issue one bus cycle, drop cyc on the terminating edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      wb_cyc <= 1'b0;
      wb_we  <= 1'b0;
      wb_adr <= '0;
      wb_dat <= '0;
      wb_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_data) begin
            state  <= DATA;
            wb_cyc <= 1'b1;
            wb_we  <= bus.i_dwe;
            wb_adr <= bus.i_daddr;
            wb_dat <= bus.i_dwdata;
            wb_sel <= bus.i_dsel;
          end else if (issue_fetch) begin
            state  <= FETCH;
            wb_cyc <= 1'b1;
            wb_we  <= 1'b0;
            wb_adr <= pc;
            wb_sel <= '1;
          end
        end
        default: begin
          if (done) begin
            state  <= IDLE;
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
          end
        end
      endcase
    end
  end

  // wait-cycle counter, only runs while a transfer is outstanding
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                      tmo_cnt <= '0;
    else if (!busy || done)           tmo_cnt <= '0;
    else if (TIMEOUT != 0)            tmo_cnt <= tmo_cnt + 1'b1;
  end

  // load/store completion pulse; error returns zero data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dack   <= 1'b0;
      derr   <= 1'b0;
      drdata <= '0;
    end else begin
      dack   <= data_done;
      derr   <= data_done & bus_err;
      drdata <= (data_done & ~bus_err) ? bus.i_wb_dat : '0;
    end
  end

  // fetch pc, halt-after-error and discard of a flushed in-flight fetch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc         <= RESET_ADDR;
      fetch_halt <= 1'b0;
      discard    <= 1'b0;
    end else if (bus.i_flush) begin
      pc         <= bus.i_flush_addr;
      fetch_halt <= 1'b0;
      discard    <= (state == FETCH) & ~done;
    end else if (fetch_done) begin
      discard <= 1'b0;
      if (!discard) begin
        if (bus_err) fetch_halt <= 1'b1;
        else         pc <= pc + ADDR_W'(DATA_W / 8);
      end
    end
  end

  // prefetch FIFO pointers and occupancy; flush empties it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage: instruction, its address and the error flag
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus_err ? '0 : bus.i_wb_dat;
      fifo_addr[wr_ptr]  <= pc;
      fifo_err[wr_ptr]   <= bus_err;
    end
  end
endmodule

// File: tb/tb_rv_bus_ctrl.sv
// Directed bench for rv_bus_ctrl with a behavioural Wishbone slave.
module tb_rv_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();

  rv_bus_ctrl #(
    .ADDR_W(32), .DATA_W(32), .PF_DEPTH(4), .RESET_ADDR(32'h0), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int cno; } iss_t;
  typedef struct { logic [31:0] instr; logic [31:0] addr; logic err; } ent_t;

  iss_t iss_q[$];
  ent_t pop_q[$];
  int cno = 0, dack_cnt = 0, total = 0, bad = 0;
  int slv_wait = 0, slv_mode = 0;   // mode 0 ack, 1 err, 2 never respond

  always @(posedge clk) cno++;

  // slave: logs each new cycle, answers after slv_wait wait states
  initial begin
    int wcnt;
    logic prev_cyc;
    wcnt = 0; prev_cyc = 1'b0;
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_dat = '0;
    forever begin
      @(posedge clk); #2;
      if (bus.o_wb_cyc) begin
        if (!prev_cyc) begin
          iss_q.push_back('{bus.o_wb_adr, bus.o_wb_we, bus.o_wb_sel, bus.o_wb_dat, cno});
          wcnt = 0;
        end
        if (slv_mode != 2 && wcnt >= slv_wait) begin
          bus.i_wb_ack = (slv_mode == 0);
          bus.i_wb_err = (slv_mode == 1);
          bus.i_wb_dat = 32'hA000_0000 | bus.o_wb_adr;
        end else begin
          bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; wcnt++;
        end
      end else begin
        bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0;
      end
      prev_cyc = bus.o_wb_cyc;
    end
  end

  // consumer side monitor
  always @(negedge clk) begin
    if (bus.o_dack) dack_cnt++;
    if (bus.o_instr_valid && bus.i_instr_ready)
      pop_q.push_back('{bus.o_instr, bus.o_instr_addr, bus.o_instr_err});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_flush = 0; bus.i_flush_addr = '0; bus.i_instr_ready = 0;
    bus.i_dreq = 0; bus.i_dwe = 0; bus.i_daddr = '0; bus.i_dwdata = '0; bus.i_dsel = '0;
    step(2);
    iss_q.delete(); pop_q.delete(); dack_cnt = 0;
    rst = 1'b0;
  endtask

  // hold the request through the dack cycle, then check it was not reissued
  task automatic data_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd, output logic er);
    int n;
    bus.i_dreq = 1; bus.i_dwe = we; bus.i_daddr = a; bus.i_dwdata = wd; bus.i_dsel = sel;
    n = 0;
    do begin step(1); n++; end while (!bus.o_dack && n < 50);
    chk("dack_seen", bus.o_dack, 1);
    rd = bus.o_drdata; er = bus.o_derr;
    step(1);
    chk("no_reissue", bus.o_wb_cyc, 0);
    bus.i_dreq = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int n_hi;
    bus.i_flush = 0; bus.i_flush_addr = '0; bus.i_instr_ready = 0;
    bus.i_dreq = 0; bus.i_dwe = 0; bus.i_daddr = '0; bus.i_dwdata = '0; bus.i_dsel = '0;
    #1 rst = 1'b1;
    step(2);
    // reset values
    chk("rst_cyc", bus.o_wb_cyc, 0);
    chk("rst_stb", bus.o_wb_stb, 0);
    chk("rst_we", bus.o_wb_we, 0);
    chk("rst_adr", bus.o_wb_adr, 0);
    chk("rst_sel", bus.o_wb_sel, 0);
    chk("rst_ivalid", bus.o_instr_valid, 0);
    chk("rst_dack", bus.o_dack, 0);
    chk("rst_derr", bus.o_derr, 0);

    // 1: zero-wait streaming fetch
    do_reset(); bus.i_instr_ready = 1; slv_wait = 0; slv_mode = 0;
    step(8);
    chk("t1_nfetch", iss_q.size(), 4);
    if (iss_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t1_adr%0d", i), iss_q[i].adr, 32'(i * 4));
        chk($sformatf("t1_sel%0d", i), {27'd0, iss_q[i].we, iss_q[i].sel}, 32'h0F);
      end
      chk("t1_gap", iss_q[1].cno - iss_q[0].cno, 2);
      chk("t1_gap2", iss_q[2].cno - iss_q[1].cno, 2);
    end
    chk("t1_npop", pop_q.size(), 3);
    if (pop_q.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t1_instr%0d", i), pop_q[i].instr, 32'hA000_0000 | 32'(i * 4));
        chk($sformatf("t1_iaddr%0d", i), pop_q[i].addr, 32'(i * 4));
      end

    // 2: FIFO fills to depth, one pop allows exactly one more fetch
    do_reset(); bus.i_instr_ready = 0;
    step(12);
    chk("t2_nfetch", iss_q.size(), 4);
    chk("t2_cyc_idle", bus.o_wb_cyc, 0);
    chk("t2_valid", bus.o_instr_valid, 1);
    chk("t2_head_addr", bus.o_instr_addr, 32'h0);
    chk("t2_head_instr", bus.o_instr, 32'hA000_0000);
    bus.i_instr_ready = 1; step(1); bus.i_instr_ready = 0;
    chk("t2_head_addr2", bus.o_instr_addr, 32'h4);
    step(6);
    chk("t2_nfetch2", iss_q.size(), 5);
    if (iss_q.size() == 5) chk("t2_adr10", iss_q[4].adr, 32'h10);

    // 3: flush during waited fetch, store pending
    do_reset(); bus.i_instr_ready = 0; slv_wait = 3;
    step(1);
    chk("t3_fetch_out", bus.o_wb_cyc, 1);
    bus.i_flush = 1; bus.i_flush_addr = 32'h200; step(1); bus.i_flush = 0;
    data_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, rd, er);
    chk("t3_derr", er, 0);
    chk("t3_fifo_empty", bus.o_instr_valid, 0);
    step(6);
    chk("t3_nissue", iss_q.size() >= 3, 1);
    if (iss_q.size() >= 3) begin
      chk("t3_f0", iss_q[0].adr, 32'h0);
      chk("t3_st_adr", iss_q[1].adr, 32'h100);
      chk("t3_st_we", iss_q[1].we, 1);
      chk("t3_st_sel", iss_q[1].sel, 4'b0011);
      chk("t3_st_dat", iss_q[1].dat, 32'hDEAD_BEEF);
      chk("t3_f200", iss_q[2].adr, 32'h200);
      chk("t3_f200_we", iss_q[2].we, 0);
    end
    chk("t3_head", bus.o_instr_addr, 32'h200);
    chk("t3_dacks", dack_cnt, 1);

    // 4: good load then errored load
    do_reset(); bus.i_instr_ready = 0; slv_wait = 0;
    data_xfer(1'b0, 32'h300, 32'h0, 4'hF, rd, er);
    chk("t4_rdata", rd, 32'hA000_0300);
    chk("t4_rerr", er, 0);
    slv_mode = 1;
    data_xfer(1'b0, 32'h304, 32'h0, 4'hF, rd, er);
    slv_mode = 0;
    chk("t4_err_rdata", rd, 32'h0);
    chk("t4_err_derr", er, 1);
    chk("t4_dacks", dack_cnt, 2);
    chk("t4_nissue", iss_q.size(), 2);

    // 5: fetch timeout, halt until flush
    do_reset(); bus.i_instr_ready = 0; slv_mode = 2;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.o_wb_cyc) n_hi++;
    end
    chk("t5_cyc_len", n_hi, 8);
    chk("t5_valid", bus.o_instr_valid, 1);
    chk("t5_ierr", bus.o_instr_err, 1);
    chk("t5_iaddr", bus.o_instr_addr, 32'h0);
    chk("t5_halted", iss_q.size(), 1);
    slv_mode = 0;
    bus.i_flush = 1; bus.i_flush_addr = 32'h40; step(1); bus.i_flush = 0;
    bus.i_instr_ready = 1;
    step(8);
    chk("t5_resume", iss_q.size() >= 2, 1);
    if (iss_q.size() >= 2) chk("t5_adr40", iss_q[1].adr, 32'h40);
    chk("t5_npop", pop_q.size() >= 1, 1);
    if (pop_q.size() >= 1) begin
      chk("t5_pop_addr", pop_q[0].addr, 32'h40);
      chk("t5_pop_err", pop_q[0].err, 0);
      chk("t5_pop_instr", pop_q[0].instr, 32'hA000_0040);
    end

    // 6: reset in the middle of a data cycle
    do_reset(); bus.i_instr_ready = 0; slv_wait = 5;
    bus.i_dreq = 1; bus.i_dwe = 0; bus.i_daddr = 32'h500; bus.i_dsel = 4'hF;
    step(2);
    chk("t6_cyc_on", bus.o_wb_cyc, 1);
    #2 rst = 1'b1;
    #1 chk("t6_cyc_async", bus.o_wb_cyc, 0);
    bus.i_dreq = 0;
    step(2);
    rst = 1'b0; iss_q.delete(); slv_wait = 0;
    step(4);
    chk("t6_nodack", dack_cnt, 0);
    chk("t6_refetch", iss_q.size() >= 1, 1);
    if (iss_q.size() >= 1) begin
      chk("t6_adr", iss_q[0].adr, 32'h0);
      chk("t6_we", iss_q[0].we, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
